cpu_mem_bridge: RTL and testbench

CPU_MEM_BRIDGE -- requirements
Module: cpu_mem_bridge

---
 rtl/cpu_mem_bridge.sv | 152 +++++++++++++++
 tb/tb_cpu_mem_bridge.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_bridge.sv
// Write-allocate bridge between a 32-bit CPU port and a 4 x 64-bit burst memory.
// Every access fills the whole 256-bit line; a write merges into it and writes the line back.
module cpu_mem_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_mbe,
    output logic [31:0] cpu_rdata,
    output logic        cpu_resp,
    output logic [31:0] pmem_addr,
    output logic        pmem_read,
    output logic        pmem_write,
    input  logic [63:0] pmem_rdata,
    output logic [63:0] pmem_wdata,
    input  logic        pmem_resp
);

    // state    | meaning
    // IDLE     | waiting for a CPU request
    // RD_BURST | filling the line buffer, 4 beats
    // MERGE    | applying CPU store bytes to the line buffer
    // WR_BURST | writing the merged line back, 4 beats
    // RESP     | one-cycle completion pulse to the CPU
    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        MERGE,
        WR_BURST,
        RESP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_beat;
    logic [255:0]  r_line;
    logic [31:2]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_mbe;
    logic          r_is_write;

    logic [7:0]    w_word_sel;
    logic [7:0]    w_beat_sel;
    logic [31:0]   w_old_word;
    logic [31:0]   w_merged;
    logic          w_unused_addr_lsbs;

    // Byte placement comes from cpu_mbe, so the low address bits carry no information.
    assign w_unused_addr_lsbs = &{1'b0, cpu_addr[1:0]};

    assign w_word_sel = {r_addr[4:2], 5'b0};
    assign w_beat_sel = {r_beat, 6'b0};
    assign w_old_word = r_line[w_word_sel +: 32];

    assign cpu_rdata  = w_old_word;
    assign pmem_addr  = {r_addr[31:5], 5'b0};
    assign pmem_wdata = r_line[w_beat_sel +: 64];

    always_comb begin
        w_merged = w_old_word;
        for (int i = 0; i < 4; i++) begin
            if (r_mbe[i]) begin
                w_merged[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        cpu_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        case (r_state)
            IDLE: begin
                // A simultaneous read and write is serviced as the write.
                if (cpu_write) begin
                    w_next = (cpu_mbe != 4'b0) ? RD_BURST : RESP;
                end else if (cpu_read) begin
                    w_next = RD_BURST;
                end
            end
            RD_BURST: begin
                pmem_read = 1'b1;
                if (pmem_resp && r_beat == 2'd3) begin
                    w_next = r_is_write ? MERGE : RESP;
                end
            end
            MERGE: begin
                w_next = WR_BURST;
            end
            WR_BURST: begin
                pmem_write = 1'b1;
                if (pmem_resp && r_beat == 2'd3) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                cpu_resp = 1'b1;
                w_next   = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_beat     <= 2'd0;
            r_line     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mbe      <= '0;
            r_is_write <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    // The latch only happens on burst entry so cpu_rdata holds until then.
                    if (w_next == RD_BURST) begin
                        r_addr     <= cpu_addr[31:2];
                        r_wdata    <= cpu_wdata;
                        r_mbe      <= cpu_mbe;
                        r_is_write <= cpu_write;
                        r_beat     <= 2'd0;
                    end
                end
                RD_BURST: begin
                    if (pmem_resp) begin
                        r_line[w_beat_sel +: 64] <= pmem_rdata;
                        r_beat                   <= r_beat + 2'd1;
                    end
                end
                MERGE: begin
                    r_line[w_word_sel +: 32] <= w_merged;
                    r_beat                   <= 2'd0;
                end
                WR_BURST: begin
                    if (pmem_resp) begin
                        r_beat <= r_beat + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed bench for cpu_mem_bridge: behavioural burst memory plus a linear
// sequence of CPU accesses with hand-computed data and latency expectations.
module tb_cpu_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_mbe;
    logic [31:0] cpu_rdata;
    logic        cpu_resp;
    logic [31:0] pmem_addr;
    logic        pmem_read;
    logic        pmem_write;
    logic [63:0] pmem_rdata;
    logic [63:0] pmem_wdata;
    logic        pmem_resp;

    int checks = 0;
    int errors = 0;

    // memory: 16 lines x 4 beats, line index = pmem_addr[8:5]
    logic [63:0] mem [0:15][0:3];
    int          mbeat;
    logic        phase;
    logic        stall_mode;
    int          wr_beats;

    int          lat;
    logic        done;
    logic        saw_rd;
    logic        saw_wr;
    logic        saw_both;
    logic        addr_bad;

    always #5 clk = ~clk;

    cpu_mem_bridge dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_wdata  (cpu_wdata),
        .cpu_mbe    (cpu_mbe),
        .cpu_rdata  (cpu_rdata),
        .cpu_resp   (cpu_resp),
        .pmem_addr  (pmem_addr),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_rdata (pmem_rdata),
        .pmem_wdata (pmem_wdata),
        .pmem_resp  (pmem_resp)
    );

    // Memory responder: decides each beat at the falling edge, DUT consumes it on the rising edge.
    always @(negedge clk) begin
        if (rst || !(pmem_read || pmem_write)) begin
            mbeat     = 0;
            phase     = 1'b0;
            pmem_resp = 1'b0;
        end else begin
            pmem_resp = stall_mode ? phase : 1'b1;
            phase     = ~phase;
            if (pmem_resp) begin
                if (pmem_read) begin
                    pmem_rdata = mem[pmem_addr[8:5]][mbeat];
                end else begin
                    mem[pmem_addr[8:5]][mbeat] = pmem_wdata;
                    wr_beats = wr_beats + 1;
                end
                mbeat = (mbeat + 1) % 4;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_pattern(input int line);
        for (int k = 0; k < 4; k++) begin
            mem[line][k] = {32'h1111_1111 * (2*k + 1), 32'h1111_1111 * (2*k)};
        end
    endtask

    // Issue one request, wait for cpu_resp (bounded), drop the request, confirm the pulse ends.
    task automatic do_req(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mbe, input int exp_lat);
        @(negedge clk);
        cpu_addr  = addr;
        cpu_read  = rd;
        cpu_write = wr;
        cpu_wdata = wdata;
        cpu_mbe   = mbe;
        wr_beats  = 0;
        lat = 0; done = 1'b0;
        saw_rd = 1'b0; saw_wr = 1'b0; saw_both = 1'b0; addr_bad = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (cpu_resp) begin
                done = 1'b1;
            end else begin
                if (pmem_read) saw_rd = 1'b1;
                if (pmem_write) saw_wr = 1'b1;
                if (pmem_read && pmem_write) saw_both = 1'b1;
                if ((pmem_read || pmem_write) && pmem_addr !== {addr[31:5], 5'b0}) addr_bad = 1'b1;
            end
        end
        check({tag, "_resp_seen"}, done, 1'b1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_addr_const"}, addr_bad, 1'b0);
        check({tag, "_rd_wr_excl"}, saw_both, 1'b0);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_resp_one_cycle"}, cpu_resp, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        cpu_addr   = '0;
        cpu_read   = 1'b0;
        cpu_write  = 1'b0;
        cpu_wdata  = '0;
        cpu_mbe    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        stall_mode = 1'b0;
        wr_beats   = 0;
        for (int l = 0; l < 16; l++) begin
            for (int k = 0; k < 4; k++) mem[l][k] = '0;
        end
        load_pattern(8);

        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_resp", cpu_resp, 1'b0);
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_pmem_addr", pmem_addr, 32'h0);
        check("rst_pmem_wdata", pmem_wdata, 64'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // zero-wait read of word 3 in line 0x100
        do_req("read", 1'b1, 1'b0, 32'h0000_010C, 32'h0, 4'h0, 5);
        check("read_data", cpu_rdata, 32'h3333_3333);
        check("read_no_write", saw_wr, 1'b0);

        // byte store into an all-zero line
        for (int k = 0; k < 4; k++) mem[8][k] = '0;
        do_req("bytewr", 1'b0, 1'b1, 32'h0000_0101, 32'h0000_AB00, 4'b0010, 10);
        check("bytewr_beat0", mem[8][0], 64'h0000_0000_0000_AB00);
        check("bytewr_beat1", mem[8][1], 64'h0);
        check("bytewr_beat2", mem[8][2], 64'h0);
        check("bytewr_beat3", mem[8][3], 64'h0);
        check("bytewr_nbeats", wr_beats, 4);
        check("bytewr_rdata", cpu_rdata, 32'h0000_AB00);

        // read with memory acking every other cycle
        load_pattern(8);
        stall_mode = 1'b1;
        do_req("stall", 1'b1, 1'b0, 32'h0000_0114, 32'h0, 4'h0, 9);
        check("stall_data", cpu_rdata, 32'h5555_5555);
        stall_mode = 1'b0;

        // write with no byte enables completes without touching memory
        do_req("mbe0", 1'b0, 1'b1, 32'h0000_0104, 32'hFFFF_FFFF, 4'h0, 1);
        check("mbe0_no_read", saw_rd, 1'b0);
        check("mbe0_no_write", saw_wr, 1'b0);
        check("mbe0_rdata_held", cpu_rdata, 32'h5555_5555);

        // reset after two read beats aborts the burst
        @(negedge clk);
        cpu_addr = 32'h0000_0108;
        cpu_read = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst      = 1'b1;
        cpu_read = 1'b0;
        @(posedge clk);
        #1;
        check("abort_pmem_read", pmem_read, 1'b0);
        check("abort_pmem_write", pmem_write, 1'b0);
        check("abort_cpu_resp", cpu_resp, 1'b0);
        check("abort_cpu_rdata", cpu_rdata, 32'h0);
        check("abort_pmem_addr", pmem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        do_req("after_abort", 1'b1, 1'b0, 32'h0000_0108, 32'h0, 4'h0, 5);
        check("after_abort_data", cpu_rdata, 32'h2222_2222);

        // back-to-back read then write to the same line
        do_req("b2b_read", 1'b1, 1'b0, 32'h0000_0118, 32'h0, 4'h0, 5);
        check("b2b_read_data", cpu_rdata, 32'h6666_6666);
        do_req("b2b_write", 1'b0, 1'b1, 32'h0000_011B, 32'hCD00_0000, 4'b1000, 10);
        check("b2b_beat0", mem[8][0], 64'h1111_1111_0000_0000);
        check("b2b_beat1", mem[8][1], 64'h3333_3333_2222_2222);
        check("b2b_beat2", mem[8][2], 64'h5555_5555_4444_4444);
        check("b2b_beat3", mem[8][3], 64'h7777_7777_CD66_6666);
        check("b2b_rdata", cpu_rdata, 32'hCD66_6666);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
